pes_vedic_mac: RTL
==================

Name: pes_vedic_mac

Overview:
- Sequential multiply-accumulate stage that sits directly downstream of the combinational 8x8 multiplier pes_vedic_mul, which it instantiates.
- Accepts a stream of LEN operand pairs over a valid/ready handshake and registers operands and products around the multiplier.
- Accumulates the products into a dot-product result and presents it on an output valid/ready handshake.

Parameters:
ACC_W, 24, accumulator/result width; must be at least 16.
CNT_W, 8, width of the run-length input and the internal counters.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin a run; sampled only in IDLE
len  input  CNT_W  number of operand pairs in the run; latched on accepted start
a  input  8  multiplicand
b  input  8  multiplier
in_valid  input  1  a/b valid
in_ready  output  1  block can accept a/b this cycle
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  ACC_W  accumulated sum of products
overflow  output  1  sticky: accumulator carried out during this run
busy  output  1  state is not IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - in_ready, out_valid, busy, overflow = 0; result = 0.
  - All counters, pipeline registers and valid bits = 0.
  - Reset asserted mid-run flushes the pipeline and discards the partial sum.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 latches len, clears the accumulator and overflow, and zeroes the accepted-count (acc_cnt) and done-count (done_cnt).
  - len!=0 -> ACCUM; len==0 -> DONE with result=0.
  - start outside IDLE is ignored.
- ACCUM:
  - in_ready = (acc_cnt < len_q); it is a register-derived signal with no combinational path from in_valid.
  - Transfer occurs when in_valid&in_ready. On transfer, a/b are captured into op regs, op_v=1, and acc_cnt increments.
  - No transfer means op_v=0.
- Pipeline:
  - Edge 1 (accepting edge): op regs loaded.
  - Edge 2: prod_r = pes_vedic_mul(op_a, op_b) (16-bit), prod_v = op_v.
  - Edge 3: if prod_v, then acc = acc + zero-extended prod_r, and done_cnt increments.
- Overflow: set if the ACC_W-bit add carries out. The accumulator wraps modulo 2^ACC_W, and overflow stays set until the next accepted start. At defaults (255*255*255 < 2^24) it cannot set.
- Run completion: when done_cnt reaches len_q on edge 3 -> DONE, and out_valid=1 from the cycle after that edge. Latency is 3 edges from acceptance of the last pair to out_valid high.
- Input bubbles (in_valid low) are allowed anywhere and simply delay completion. Pairs offered after acc_cnt==len_q are not accepted (in_ready=0).
- DONE:
  - out_valid=1; result and overflow are held stable while out_ready=0.
  - out_valid&out_ready -> IDLE, out_valid=0. result keeps its value until the next accepted start.
  - start during DONE is ignored, even in the handoff cycle.
- result is driven directly from the accumulator register.
- busy=1 in ACCUM and DONE.

Decomposition:
- Shared package pes_vedic_pkg holds:
  - state enum {IDLE, ACCUM, DONE};
  - OP_W=8 and PROD_W=16 constants;
  - default ACC_W/CNT_W.
- The existing pes_vedic_mul is instantiated unchanged as the single sub-module. No other sub-modules; FSM, counters and pipeline live in pes_vedic_mac.

Test Plan:
1. Reset: hold rst_n=0, toggle inputs -> in_ready=0, out_valid=0, busy=0, overflow=0, result=0. Then assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately.
2. start, len=3, back-to-back pairs (3,4),(5,6),(255,255) with out_ready=1 -> result=65067, overflow=0. out_valid rises 3 edges after the (255,255) acceptance and lasts 1 cycle; then IDLE, busy=0.
3. len=4, pairs (1,1),(2,2),(10,20),(7,9) with in_valid low 2 cycles between pairs, a 5th pair offered, out_ready=0 for 5 cycles -> 5th pair not accepted. result=268 held stable with out_valid=1 for all 5 cycles; clears after out_ready.
4. start with len=0 -> DONE next cycle, out_valid=1, result=0. A start pulse during DONE -> ignored.
5. ACC_W=17, len=3, pairs (255,255) x3 -> overflow=1, result=64003 (195075 mod 131072). Next start clears overflow.
6. start len=5, accept 2 pairs, pulse rst_n=0 -> all outputs 0, pipeline flushed. start len=1, pair (2,3) -> result=6, overflow=0.

Source files
------------

// File: rtl/pes_vedic_pkg.sv
// pes_vedic_pkg: shared types and constants for the vedic multiply-accumulate slice
package pes_vedic_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int OP_W = 8;
    localparam int PROD_W = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/pes_vedic_mac_if.sv
// pes_vedic_mac_if: run control, operand stream and result handshake of the vedic MAC
interface pes_vedic_mac_if import pes_vedic_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic start;
    logic [CNT_W-1:0] len;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic [ACC_W-1:0] result;
    logic overflow;
    logic busy;
    modport master (
        output start, len, a, b, in_valid, out_ready,
        input in_ready, out_valid, result, overflow, busy
    );
    modport slave (
        input start, len, a, b, in_valid, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );
endinterface

// File: rtl/pes_vedic_mul.sv
// pes_vedic_mul: combinational 8x8 vedic (urdhva tiryagbhyam) multiplier
module pes_vedic_mul import pes_vedic_pkg::*; (
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);
    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic c;
        logic s;
        logic h;
        {c, s} = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
        h = x[1] & y[1];
        return {h & c, h ^ c, s, x[0] & y[0]};
    endfunction
    function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = v2(x[1:0], y[1:0]);
        q1 = v2(x[3:2], y[1:0]);
        q2 = v2(x[1:0], y[3:2]);
        q3 = v2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction
    logic [7:0] r0, r1, r2, r3;
    assign r0 = v4(a[3:0], b[3:0]);
    assign r1 = v4(a[7:4], b[3:0]);
    assign r2 = v4(a[3:0], b[7:4]);
    assign r3 = v4(a[7:4], b[7:4]);
    assign p = {8'b0, r0} + {4'b0, r1, 4'b0} + {4'b0, r2, 4'b0} + {r3, 8'b0};
endmodule

// File: rtl/pes_vedic_mac.sv
// pes_vedic_mac: streams LEN operand pairs through pes_vedic_mul and accumulates a dot product
// Pipeline: accept -> op regs, -> prod_r, -> accumulator; result is the accumulator itself.
module pes_vedic_mac import pes_vedic_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic clk,
    input logic rst_n,
    pes_vedic_mac_if.slave bus
);
    state_t state, nstate;
    logic [CNT_W-1:0] len_q, acc_cnt, done_cnt;
    logic [OP_W-1:0] op_a, op_b;
    logic op_v, prod_v, ovf, take, go, last;
    logic [PROD_W-1:0] prod, prod_r;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0] sum;
    pes_vedic_mul u_mul (.a(op_a), .b(op_b), .p(prod));
    assign bus.in_ready = (state == ACCUM) && (acc_cnt < len_q);
    assign bus.out_valid = state == DONE;
    assign bus.busy = state != IDLE;
    assign bus.result = acc;
    assign bus.overflow = ovf;
    assign take = bus.in_valid & bus.in_ready;
    assign go = (state == IDLE) & bus.start;
    // the final product lands on the same edge that enters DONE
    assign last = prod_v && (done_cnt + 1'b1 == len_q);
    assign sum = {1'b0, acc} + (ACC_W+1)'(prod_r);
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = bus.start ? (bus.len == '0 ? DONE : ACCUM) : IDLE;
            ACCUM:   nstate = last ? DONE : ACCUM;
            DONE:    nstate = bus.out_ready ? IDLE : DONE;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len_q <= '0;
            acc_cnt <= '0;
            done_cnt <= '0;
            op_a <= '0;
            op_b <= '0;
            op_v <= 1'b0;
            prod_r <= '0;
            prod_v <= 1'b0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            state <= nstate;
            op_v <= take;
            prod_v <= op_v;
            prod_r <= prod;
            if (take) begin
                op_a <= bus.a;
                op_b <= bus.b;
            end
            if (go) begin
                len_q <= bus.len;
                acc_cnt <= '0;
                done_cnt <= '0;
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                if (take) acc_cnt <= acc_cnt + 1'b1;
                if (prod_v) begin
                    acc <= sum[ACC_W-1:0];
                    ovf <= ovf | sum[ACC_W];
                    done_cnt <= done_cnt + 1'b1;
                end
            end
        end
    end
endmodule
